led_fader: RTL

Downstream LED stage for the board top level: consumes a per-LED on/off pattern (e.g. low bits of the blinker counter) through a valid/ready handshake and drives the LED pins with PWM, ramping each LED's brightness linearly toward its new target instead of switching hard. It holds one pattern in a pending buffer while a fade is in progress, so the producer never needs to track fade timing.

---
 rtl/led_fader_pkg.sv | 11 +
 rtl/led_fader_if.sv | 15 +
 rtl/led_fader_channel.sv | 50 +++++
 rtl/led_fader.sv | 102 ++++++++++
 4 files changed

// File: rtl/led_fader_pkg.sv
// led_fader_pkg: shared state type, default parameters and FULL-level helper for the LED fader
package led_fader_pkg;
    localparam int DEF_CHANNELS  = 4;
    localparam int DEF_PWM_BITS  = 8;
    localparam int DEF_STEP_DIV  = 1024;
    localparam int DEF_FADE_STEP = 8;
    typedef enum logic {IDLE, FADE} state_t;
    function automatic int full_of(input int bits);
        return (1 << bits) - 1;
    endfunction
endpackage

// File: rtl/led_fader_if.sv
// led_fader_if: pattern valid/ready channel into the LED fader
//   pattern       : per-LED on/off target bits
//   pattern_valid : producer has a pattern this cycle
//   pattern_ready : fader accepts a pattern this cycle
interface led_fader_if
    import led_fader_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS
);
    logic [CHANNELS-1:0] pattern;
    logic                pattern_valid;
    logic                pattern_ready;
    modport master (output pattern, pattern_valid, input pattern_ready);
    modport slave (input pattern, pattern_valid, output pattern_ready);
endinterface

// File: rtl/led_fader_channel.sv
// led_fader_channel: one LED's brightness ramp toward its target plus registered PWM output
//   clk, rst_n : clock, asynchronous active-low reset
//   i_step     : move one FADE_STEP toward i_target this cycle
//   i_target   : brightness goal (0 or FULL)
//   i_pwm_cnt  : shared free-running PWM counter
//   o_level    : current brightness
//   o_led      : PWM-driven LED pin, one cycle behind o_level
module led_fader_channel
    import led_fader_pkg::*;
#(
    parameter int PWM_BITS  = DEF_PWM_BITS,
    parameter int FADE_STEP = DEF_FADE_STEP
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_step,
    input  logic [PWM_BITS-1:0] i_target,
    input  logic [PWM_BITS-1:0] i_pwm_cnt,
    output logic [PWM_BITS-1:0] o_level,
    output logic                o_led
);
    localparam logic [PWM_BITS-1:0] FULL = PWM_BITS'(full_of(PWM_BITS));
    localparam logic [PWM_BITS:0]   STEP = (PWM_BITS + 1)'(FADE_STEP);
    logic [PWM_BITS-1:0] r_level;
    logic [PWM_BITS-1:0] w_level_nxt;
    logic [PWM_BITS:0]   w_up;
    logic [PWM_BITS:0]   w_dn;
    logic                r_led;
    assign w_up = {1'b0, r_level} + STEP;
    // top bit of w_dn is the borrow: set when the step would pass below zero
    assign w_dn = {1'b0, r_level} - STEP;
    always_comb begin
        w_level_nxt = !i_step ? r_level :
                      (r_level < i_target) ? ((w_up >= {1'b0, i_target}) ? i_target : w_up[PWM_BITS-1:0]) :
                      (r_level > i_target) ? ((w_dn[PWM_BITS] || w_dn[PWM_BITS-1:0] <= i_target) ? i_target : w_dn[PWM_BITS-1:0]) :
                      r_level;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
            r_led   <= 1'b0;
        end else begin
            r_level <= w_level_nxt;
            // FULL must be solid on, since pwm_cnt never exceeds FULL
            r_led   <= (r_level == FULL) || (r_level > i_pwm_cnt);
        end
    end
    assign o_level = r_level;
    assign o_led   = r_led;
endmodule

// File: rtl/led_fader.sv
// led_fader: accepts LED on/off patterns and fades each LED linearly to its new brightness via PWM
//   clk, rst_n : clock, asynchronous active-low reset
//   s_pat      : pattern valid/ready channel (slave side)
//   o_led      : PWM-driven LED pins, active-high
//   o_busy     : a fade is in progress
module led_fader
    import led_fader_pkg::*;
#(
    parameter int CHANNELS  = DEF_CHANNELS,
    parameter int PWM_BITS  = DEF_PWM_BITS,
    parameter int STEP_DIV  = DEF_STEP_DIV,
    parameter int FADE_STEP = DEF_FADE_STEP
) (
    input  logic                clk,
    input  logic                rst_n,
    led_fader_if.slave          s_pat,
    output logic [CHANNELS-1:0] o_led,
    output logic                o_busy
);
    localparam logic [PWM_BITS-1:0] FULL = PWM_BITS'(full_of(PWM_BITS));
    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    state_t              r_state;
    state_t              w_state_nxt;
    logic [PW-1:0]       r_prescaler;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [CHANNELS-1:0] r_target;
    logic [CHANNELS-1:0] w_target_nxt;
    logic [CHANNELS-1:0] r_pending;
    logic [CHANNELS-1:0] w_pending_nxt;
    logic                r_pending_full;
    logic                w_pending_full_nxt;
    logic                w_accept;
    logic                w_tick;
    logic                w_step;
    logic                w_done;
    logic [CHANNELS-1:0] w_match;
    logic [PWM_BITS-1:0] w_level [CHANNELS];
    assign s_pat.pattern_ready = !r_pending_full;
    assign w_accept = s_pat.pattern_valid && !r_pending_full;
    assign w_tick   = r_prescaler == PW'(STEP_DIV - 1);
    assign w_step   = w_tick && (r_state == FADE);
    assign w_done   = &w_match;
    assign o_busy   = r_state == FADE;
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        led_fader_channel #(
            .PWM_BITS (PWM_BITS),
            .FADE_STEP(FADE_STEP)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_step   (w_step),
            .i_target (r_target[i] ? FULL : '0),
            .i_pwm_cnt(r_pwm_cnt),
            .o_level  (w_level[i]),
            .o_led    (o_led[i])
        );
        assign w_match[i] = w_level[i] == (r_target[i] ? FULL : '0);
    end
    // Completion is checked every cycle, so a finished fade hands over to the
    // pending pattern (or a same-cycle accept) without an IDLE gap.
    always_comb begin
        w_state_nxt        = r_state;
        w_target_nxt       = r_target;
        w_pending_nxt      = r_pending;
        w_pending_full_nxt = r_pending_full;
        if (r_state == IDLE) begin
            if (w_accept) begin
                w_target_nxt = s_pat.pattern;
                w_state_nxt  = FADE;
            end
        end else if (w_done) begin
            if (r_pending_full) begin
                w_target_nxt       = r_pending;
                w_pending_full_nxt = 1'b0;
            end else if (w_accept) begin
                w_target_nxt = s_pat.pattern;
            end else begin
                w_state_nxt = IDLE;
            end
        end else if (w_accept) begin
            w_pending_nxt      = s_pat.pattern;
            w_pending_full_nxt = 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_target       <= '0;
            r_pending      <= '0;
            r_pending_full <= 1'b0;
            r_prescaler    <= '0;
            r_pwm_cnt      <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_target       <= w_target_nxt;
            r_pending      <= w_pending_nxt;
            r_pending_full <= w_pending_full_nxt;
            r_prescaler    <= w_tick ? '0 : r_prescaler + 1'b1;
            r_pwm_cnt      <= r_pwm_cnt + 1'b1;
        end
    end
endmodule
